// File: rtl/saat_uart_tx.sv
// UART time reporter: on request, snapshots the hours/minutes/seconds inputs
// and sends "HH:MM:SS\r\n" as ten back-to-back 8N1 characters.
module saat_uart_tx #(
  parameter int CLK_FREQ = 100000000,
  parameter int BAUD     = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       send,
  input  logic [4:0] saat,
  input  logic [5:0] dakika,
  input  logic [5:0] saniye,
  output logic       RsTx,
  output logic       busy,
  output logic       done
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [3:0]       char_q, char_d;
  logic [2:0]       bit_q, bit_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       saat_q, saat_d;
  logic [5:0]       dk_q, dk_d;
  logic [5:0]       sn_q, sn_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [7:0]       cur_char;
  logic             bit_end;

  // ASCII tens digit; values above 99 are not clamped by design.
  function automatic logic [7:0] tens_ascii(input logic [5:0] v);
    logic [5:0] t;
    t = v / 6'd10;
    return 8'h30 + {2'b00, t};
  endfunction

  function automatic logic [7:0] ones_ascii(input logic [5:0] v);
    logic [5:0] o;
    o = v % 6'd10;
    return 8'h30 + {2'b00, o};
  endfunction

  // Character currently being framed, selected by the character index.
  always_comb begin
    cur_char = 8'h0A;
    case (char_q)
      4'd0: cur_char = tens_ascii({1'b0, saat_q});
      4'd1: cur_char = ones_ascii({1'b0, saat_q});
      4'd2: cur_char = 8'h3A;
      4'd3: cur_char = tens_ascii(dk_q);
      4'd4: cur_char = ones_ascii(dk_q);
      4'd5: cur_char = 8'h3A;
      4'd6: cur_char = tens_ascii(sn_q);
      4'd7: cur_char = ones_ascii(sn_q);
      4'd8: cur_char = 8'h0D;
      default: cur_char = 8'h0A;
    endcase
  end

  assign bit_end = (cnt_q == CNT_LAST);

  // Next-state logic; the line level is computed one cycle ahead so RsTx is a register.
  always_comb begin
    state_d = state_q;
    char_d  = char_q;
    bit_d   = bit_q;
    cnt_d   = cnt_q;
    saat_d  = saat_q;
    dk_d    = dk_q;
    sn_d    = sn_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (send) begin
          saat_d  = saat;
          dk_d    = dakika;
          sn_d    = saniye;
          state_d = S_START;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
          cnt_d   = '0;
          char_d  = 4'd0;
          bit_d   = 3'd0;
        end
      end
      S_START: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = S_DATA;
          bit_d   = 3'd0;
          tx_d    = cur_char[0];
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = cur_char[bit_q + 3'd1];
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (bit_end) begin
          cnt_d = '0;
          if (char_q != 4'd9) begin
            // Next character starts immediately: no inter-character gap.
            char_d  = char_q + 4'd1;
            state_d = S_START;
            tx_d    = 1'b0;
          end else begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State registers; reset aborts any report at once and parks the line high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      char_q  <= 4'd0;
      bit_q   <= 3'd0;
      cnt_q   <= '0;
      saat_q  <= 5'd0;
      dk_q    <= 6'd0;
      sn_q    <= 6'd0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      char_q  <= char_d;
      bit_q   <= bit_d;
      cnt_q   <= cnt_d;
      saat_q  <= saat_d;
      dk_q    <= dk_d;
      sn_q    <= sn_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign RsTx = tx_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_saat_uart_tx.sv
// Directed bench for saat_uart_tx at 10 clocks per bit.
module tb_saat_uart_tx;

  logic       clk;
  logic       rst;
  logic       send;
  logic [4:0] saat;
  logic [5:0] dakika;
  logic [5:0] saniye;
  logic       RsTx;
  logic       busy;
  logic       done;

  int errors;
  int checks;
  int busy_total;
  int done_total;

  saat_uart_tx #(.CLK_FREQ(1000), .BAUD(100)) dut (
    .clk(clk), .rst(rst), .send(send), .saat(saat), .dakika(dakika),
    .saniye(saniye), .RsTx(RsTx), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Running totals of busy cycles and done pulses (pre-edge values).
  initial begin
    busy_total = 0;
    done_total = 0;
  end
  always @(posedge clk) begin
    if (busy === 1'b1) busy_total <= busy_total + 1;
    if (done === 1'b1) done_total <= done_total + 1;
  end

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_vec(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic send_pulse();
    @(negedge clk);
    send = 1'b1;
    @(negedge clk);
    send = 1'b0;
  endtask

  // Decode one 8N1 character starting from the current negedge.
  task automatic get_byte(output logic [7:0] b);
    int n;
    logic [7:0] v;
    n = 0;
    while (RsTx !== 1'b0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk_bit("rx_start_edge", RsTx, 1'b0);
    repeat (4) @(negedge clk);
    chk_bit("rx_start_mid", RsTx, 1'b0);
    for (int i = 0; i < 8; i++) begin
      repeat (10) @(negedge clk);
      v[i] = RsTx;
    end
    repeat (10) @(negedge clk);
    chk_bit("rx_stop_bit", RsTx, 1'b1);
    b = v;
  endtask

  task automatic recv_report(output logic [79:0] r);
    logic [7:0] b;
    r = '0;
    for (int i = 0; i < 10; i++) begin
      get_byte(b);
      r = {r[71:0], b};
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (done !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk_bit("done_seen", done, 1'b1);
  endtask

  initial begin
    logic [79:0] rep;
    logic [79:0] exp_rep;
    logic [9:0]  frame;
    logic [9:0]  samp;
    logic [7:0]  b0;
    int busy0;
    int done0;

    errors = 0;
    checks = 0;
    rst    = 1'b1;
    send   = 1'b0;
    saat   = 5'd0;
    dakika = 6'd0;
    saniye = 6'd0;

    // Reset state.
    repeat (3) @(negedge clk);
    chk_bit("rst_RsTx", RsTx, 1'b1);
    chk_bit("rst_busy", busy, 1'b0);
    chk_bit("rst_done", done, 1'b0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk_bit("idle_RsTx", RsTx, 1'b1);

    // 12:30:05, with the first character's waveform checked cycle by cycle.
    saat = 5'd12; dakika = 6'd30; saniye = 6'd5;
    busy0 = busy_total; done0 = done_total;
    send_pulse();
    chk_bit("accept_busy", busy, 1'b1);
    frame = {1'b1, 8'h31, 1'b0};
    for (int k = 0; k < 10; k++) begin
      for (int c = 0; c < 10; c++) begin
        samp[c] = RsTx;
        @(negedge clk);
      end
      if (k >= 1 && k <= 8) b0[k-1] = samp[5];
      chk_vec($sformatf("char0_bit%0d", k), {70'd0, samp}, frame[k] ? 80'h3FF : 80'h0);
    end
    rep = {72'd0, b0};
    for (int i = 1; i < 10; i++) begin
      logic [7:0] b;
      get_byte(b);
      rep = {rep[71:0], b};
    end
    exp_rep = "12:30:05\r\n";
    chk_vec("report_12_30_05", rep, exp_rep);
    wait_done();
    chk_bit("done_busy_low", busy, 1'b0);
    @(negedge clk);
    chk_bit("done_one_cycle", done, 1'b0);
    @(negedge clk);
    chk_int("busy_cycles_1", busy_total - busy0, 1000);
    chk_int("done_pulses_1", done_total - done0, 1);

    // Snapshot holds; a second send mid-report is ignored.
    saat = 5'd7; dakika = 6'd8; saniye = 6'd9;
    busy0 = busy_total; done0 = done_total;
    send_pulse();
    saat = 5'd1; dakika = 6'd2; saniye = 6'd3;
    rep = '0;
    for (int i = 0; i < 10; i++) begin
      logic [7:0] b;
      get_byte(b);
      rep = {rep[71:0], b};
      if (i == 3) send_pulse();
    end
    exp_rep = "07:08:09\r\n";
    chk_vec("report_snapshot", rep, exp_rep);
    wait_done();
    repeat (3) @(negedge clk);
    chk_bit("no_restart_busy", busy, 1'b0);
    chk_int("busy_cycles_2", busy_total - busy0, 1000);
    chk_int("done_pulses_2", done_total - done0, 1);

    // send held high: back-to-back reports with one idle cycle.
    saat = 5'd1; dakika = 6'd2; saniye = 6'd3;
    busy0 = busy_total; done0 = done_total;
    @(negedge clk);
    send = 1'b1;
    @(negedge clk);
    recv_report(rep);
    exp_rep = "01:02:03\r\n";
    chk_vec("report_b2b_1", rep, exp_rep);
    wait_done();
    chk_bit("b2b_gap_RsTx", RsTx, 1'b1);
    chk_bit("b2b_gap_busy", busy, 1'b0);
    @(negedge clk);
    chk_bit("b2b_restart_RsTx", RsTx, 1'b0);
    chk_bit("b2b_restart_busy", busy, 1'b1);
    send = 1'b0;
    recv_report(rep);
    chk_vec("report_b2b_2", rep, exp_rep);
    wait_done();
    repeat (2) @(negedge clk);
    chk_bit("b2b_end_busy", busy, 1'b0);
    chk_int("busy_cycles_b2b", busy_total - busy0, 2000);
    chk_int("done_pulses_b2b", done_total - done0, 2);

    // Asynchronous reset mid-report.
    saat = 5'd4; dakika = 6'd5; saniye = 6'd6;
    send_pulse();
    repeat (249) @(negedge clk);
    chk_bit("pre_rst_busy", busy, 1'b1);
    rst = 1'b1;
    #1;
    chk_bit("async_rst_RsTx", RsTx, 1'b1);
    chk_bit("async_rst_busy", busy, 1'b0);
    @(negedge clk);
    chk_bit("async_rst_done", done, 1'b0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk_bit("post_rst_idle_busy", busy, 1'b0);
    chk_bit("post_rst_idle_RsTx", RsTx, 1'b1);
    saat = 5'd23; dakika = 6'd59; saniye = 6'd59;
    send_pulse();
    recv_report(rep);
    exp_rep = "23:59:59\r\n";
    chk_vec("report_after_rst", rep, exp_rep);
    wait_done();

    // Out-of-range values are not clamped.
    saat = 5'd31; dakika = 6'd63; saniye = 6'd0;
    send_pulse();
    recv_report(rep);
    exp_rep = "31:63:00\r\n";
    chk_vec("report_out_of_range", rep, exp_rep);
    wait_done();
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/saat_uart_tx.md
SAAT_UART_TX -- requirements
Module: saat_uart_tx

Interface
REQ-001 The block SHALL have parameter CLK_FREQ, default 100000000, giving the input clock frequency in Hz.
REQ-002 The block SHALL have parameter BAUD, default 9600, giving the serial bit rate.
REQ-003 The block SHALL derive CLKS_PER_BIT = CLK_FREQ / BAUD using integer division (10416 at the defaults).
REQ-004 Port clk, input, 1 bit: single system clock; all logic on its rising edge.
REQ-005 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 Port send, input, 1 bit: request to transmit one time report; sampled each clock.
REQ-007 Port saat, input, 5 bits: hours value, binary.
REQ-008 Port dakika, input, 6 bits: minutes value, binary.
REQ-009 Port saniye, input, 6 bits: seconds value, binary.
REQ-010 Port RsTx, output, 1 bit: UART serial line, 8N1, idle high; driven from a register.
REQ-011 Port busy, output, 1 bit: high while a report is in progress.
REQ-012 Port done, output, 1 bit: one-cycle pulse when a report completes.

Function
REQ-013 A report SHALL be the 10-byte ASCII string "HH:MM:SS" followed by 0x0D, then 0x0A.
REQ-014 Each digit pair SHALL be formed as (value/10)+0x30 and (value%10)+0x30, with no range clamping.
- Out-of-range inputs follow the same rule; saat=31 sends "31" and dakika=63 sends "63".
REQ-015 When send=1 and busy=0 at a rising edge, the block SHALL latch saat, dakika and saniye into a snapshot.
- Input changes after that edge SHALL NOT affect the report in progress.
REQ-016 When busy=1, send SHALL be ignored; no queuing, no restart.
REQ-017 The FSM SHALL have states IDLE, START, DATA, STOP plus a 4-bit character index 0..9 and a 3-bit bit index.
REQ-018 IDLE -> START on an accepted send.
- RsTx SHALL go low and busy SHALL go high on the cycle after the accepting edge (1-cycle latency).
REQ-019 START SHALL hold RsTx=0 for exactly CLKS_PER_BIT cycles, then go to DATA.
REQ-020 DATA SHALL send 8 bits LSB first, each for exactly CLKS_PER_BIT cycles, then go to STOP.
REQ-021 STOP SHALL hold RsTx=1 for exactly CLKS_PER_BIT cycles.
- If the character index is below 9: increment it and go to START immediately, with no inter-character gap.
- If the index is 9: go to IDLE.
REQ-022 The baud counter SHALL reset to 0 at every bit boundary.
REQ-023 A full report SHALL occupy exactly 100*CLKS_PER_BIT cycles of busy=1 (1041600 at the defaults).
REQ-024 On the cycle the FSM returns to IDLE, busy SHALL fall to 0 and done SHALL be 1 for exactly one cycle.
REQ-025 A send asserted in the same cycle that done=1 SHALL be accepted.
- The next START bit SHALL follow with the 1-cycle latency of REQ-018.
REQ-026 In IDLE, RsTx SHALL be 1.

Reset
REQ-027 While rst=1, the block SHALL hold RsTx=1, busy=0, done=0, state=IDLE, and all counters and the snapshot at 0.
REQ-028 rst asserted mid-frame SHALL abort the report immediately (asynchronously), with no partial stop bit.
- After rst deasserts, the block SHALL wait in IDLE for a new send.
REQ-029 The first accepted send after reset SHALL produce a complete, correctly framed report.

Verification
REQ-030 CLK_FREQ=1000, BAUD=100 (10 clk/bit); saat=12, dakika=30, saniye=5; pulse send -> line decodes "12:30:05\r\n"; busy high for 1000 cycles; one done pulse.
REQ-031 Same parameters; first byte 0x31 -> RsTx low for 10 cycles, then 1,0,0,0,1,1,0,0 for 10 cycles each, then high for 10 cycles.
REQ-032 send pulsed again at cycle 400 of a report, and the inputs changed after acceptance -> no restart, and the transmitted digits equal the snapshot.
REQ-033 send held high continuously -> back-to-back reports, each separated from the previous by exactly 1 idle cycle after done.
REQ-034 rst asserted at cycle 250 of a report -> RsTx=1 and busy=0 immediately; a later send with 23:59:59 -> "23:59:59\r\n".
REQ-035 saat=31, dakika=63, saniye=0 -> "31:63:00\r\n".
